// File: rtl/fp_adder_normalize_shifter.sv
// ============================================================================
// Module   : fp_adder_normalize_shifter
// Brief    : FP adder normalization stage (decode + left-shift), 2-stage
//            valid/ready pipeline driven by the leading-one position code.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_adder_normalize_shifter #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8,
    parameter int POS_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sign_in,
    input  logic [EXP_W-1:0]  exp_in,
    input  logic [MANT_W-1:0] mant_in,
    input  logic [POS_W-1:0]  pos_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              sign_out,
    output logic [EXP_W-1:0]  exp_out,
    output logic [MANT_W-1:0] mant_out,
    output logic [MANT_W-1:0] lead_onehot,
    output logic              zero_flag,
    output logic              uflow_flag,
    output logic              err_flag
);

    localparam logic [POS_W-1:0] c_max_pos = POS_W'(MANT_W);

    typedef enum logic [1:0] {
        CLS_NORM  = 2'd0,
        CLS_ZERO  = 2'd1,
        CLS_UFLOW = 2'd2,
        CLS_ERR   = 2'd3
    } cls_t;

    logic              w_adv;
    logic [POS_W-1:0]  w_shamt;
    logic [MANT_W-1:0] w_onehot;
    cls_t              w_cls;

    // Stage-1 registers
    logic              s1_valid_q,  s1_valid_d;
    logic              s1_sign_q,   s1_sign_d;
    logic [EXP_W-1:0]  s1_exp_q,    s1_exp_d;
    logic [MANT_W-1:0] s1_mant_q,   s1_mant_d;
    logic [POS_W-1:0]  s1_shamt_q,  s1_shamt_d;
    logic [MANT_W-1:0] s1_onehot_q, s1_onehot_d;
    cls_t              s1_cls_q,    s1_cls_d;

    // Stage-2 (output) registers
    logic              out_valid_q,   out_valid_d;
    logic              sign_out_q,    sign_out_d;
    logic [EXP_W-1:0]  exp_out_q,     exp_out_d;
    logic [MANT_W-1:0] mant_out_q,    mant_out_d;
    logic [MANT_W-1:0] lead_onehot_q, lead_onehot_d;
    logic              zero_flag_q,   zero_flag_d;
    logic              uflow_flag_q,  uflow_flag_d;
    logic              err_flag_q,    err_flag_d;

    // Whole pipeline moves in lock-step; ready never depends on in_valid.
    assign w_adv    = !out_valid_q || out_ready;
    assign in_ready = w_adv;

    assign w_shamt = c_max_pos - pos_in;

    // Codes 0 and 25..31 match no bit, so the decode is naturally all-zero.
    for (genvar i = 0; i < MANT_W; i++) begin : g_onehot
        assign w_onehot[i] = (pos_in == POS_W'(i + 1));
    end

    always_comb begin
        w_cls = CLS_NORM;
        if (pos_in > c_max_pos) begin
            w_cls = CLS_ERR;
        end else if (pos_in == '0) begin
            w_cls = CLS_ZERO;
        end else if (exp_in <= EXP_W'(w_shamt)) begin
            w_cls = CLS_UFLOW;
        end
    end

    always_comb begin
        s1_valid_d    = s1_valid_q;
        s1_sign_d     = s1_sign_q;
        s1_exp_d      = s1_exp_q;
        s1_mant_d     = s1_mant_q;
        s1_shamt_d    = s1_shamt_q;
        s1_onehot_d   = s1_onehot_q;
        s1_cls_d      = s1_cls_q;
        out_valid_d   = out_valid_q;
        sign_out_d    = sign_out_q;
        exp_out_d     = exp_out_q;
        mant_out_d    = mant_out_q;
        lead_onehot_d = lead_onehot_q;
        zero_flag_d   = zero_flag_q;
        uflow_flag_d  = uflow_flag_q;
        err_flag_d    = err_flag_q;

        if (w_adv) begin
            s1_valid_d  = in_valid;
            out_valid_d = s1_valid_q;

            if (in_valid) begin
                s1_sign_d   = sign_in;
                s1_exp_d    = exp_in;
                s1_mant_d   = mant_in;
                s1_shamt_d  = w_shamt;
                s1_onehot_d = w_onehot;
                s1_cls_d    = w_cls;
            end

            if (s1_valid_q) begin
                lead_onehot_d = s1_onehot_q;
                sign_out_d    = 1'b0;
                exp_out_d     = '0;
                mant_out_d    = '0;
                zero_flag_d   = (s1_cls_q == CLS_ZERO);
                uflow_flag_d  = (s1_cls_q == CLS_UFLOW);
                err_flag_d    = (s1_cls_q == CLS_ERR);
                if (s1_cls_q == CLS_NORM) begin
                    sign_out_d = s1_sign_q;
                    exp_out_d  = s1_exp_q - EXP_W'(s1_shamt_q);
                    mant_out_d = s1_mant_q << s1_shamt_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q    <= 1'b0;
            s1_sign_q     <= 1'b0;
            s1_exp_q      <= '0;
            s1_mant_q     <= '0;
            s1_shamt_q    <= '0;
            s1_onehot_q   <= '0;
            s1_cls_q      <= CLS_NORM;
            out_valid_q   <= 1'b0;
            sign_out_q    <= 1'b0;
            exp_out_q     <= '0;
            mant_out_q    <= '0;
            lead_onehot_q <= '0;
            zero_flag_q   <= 1'b0;
            uflow_flag_q  <= 1'b0;
            err_flag_q    <= 1'b0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_sign_q     <= s1_sign_d;
            s1_exp_q      <= s1_exp_d;
            s1_mant_q     <= s1_mant_d;
            s1_shamt_q    <= s1_shamt_d;
            s1_onehot_q   <= s1_onehot_d;
            s1_cls_q      <= s1_cls_d;
            out_valid_q   <= out_valid_d;
            sign_out_q    <= sign_out_d;
            exp_out_q     <= exp_out_d;
            mant_out_q    <= mant_out_d;
            lead_onehot_q <= lead_onehot_d;
            zero_flag_q   <= zero_flag_d;
            uflow_flag_q  <= uflow_flag_d;
            err_flag_q    <= err_flag_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign sign_out    = sign_out_q;
    assign exp_out     = exp_out_q;
    assign mant_out    = mant_out_q;
    assign lead_onehot = lead_onehot_q;
    assign zero_flag   = zero_flag_q;
    assign uflow_flag  = uflow_flag_q;
    assign err_flag    = err_flag_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_adder_normalize_shifter.sv
// ============================================================================
// Module   : tb_fp_adder_normalize_shifter
// Brief    : Scoreboard bench for the FP adder normalization stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_adder_normalize_shifter;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [23:0] mant;
        logic [23:0] onehot;
        logic        zf;
        logic        uf;
        logic        ef;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        sign_in;
    logic [7:0]  exp_in;
    logic [23:0] mant_in;
    logic [4:0]  pos_in;
    logic        out_valid;
    logic        out_ready;
    logic        sign_out;
    logic [7:0]  exp_out;
    logic [23:0] mant_out;
    logic [23:0] lead_onehot;
    logic        zero_flag;
    logic        uflow_flag;
    logic        err_flag;

    int    checks   = 0;
    int    failures = 0;
    beat_t sb[$];

    fp_adder_normalize_shifter #(.MANT_W(24), .EXP_W(8), .POS_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sign_in    (sign_in),
        .exp_in     (exp_in),
        .mant_in    (mant_in),
        .pos_in     (pos_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sign_out   (sign_out),
        .exp_out    (exp_out),
        .mant_out   (mant_out),
        .lead_onehot(lead_onehot),
        .zero_flag  (zero_flag),
        .uflow_flag (uflow_flag),
        .err_flag   (err_flag)
    );

    always #5 clk = ~clk;

    function automatic beat_t mk(input logic s, input logic [7:0] e, input logic [23:0] m,
                                 input logic [23:0] oh, input logic z, input logic u, input logic er);
        beat_t b;
        b.sign = s; b.exp = e; b.mant = m; b.onehot = oh; b.zf = z; b.uf = u; b.ef = er;
        return b;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Caller enters at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic send(input logic s, input logic [7:0] e, input logic [23:0] m,
                        input logic [4:0] p, input beat_t exp_b);
        bit done = 0;
        sign_in  = s;
        exp_in   = e;
        mant_in  = m;
        pos_in   = p;
        in_valid = 1'b1;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(exp_b);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready stayed 0 for pos=%0d", p);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 50 && sb.size() != 0; k++) @(posedge clk);
        #1;
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: a beat retires on the edge following a negedge with valid && ready.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            beat_t act;
            beat_t req;
            act = {sign_out, exp_out, mant_out, lead_onehot, zero_flag, uflow_flag, err_flag};
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_beat: got 0x%0h expected no beat", act);
            end else begin
                req = sb.pop_front();
                if (act !== req) begin
                    failures++;
                    $display("FAIL out_beat: got 0x%0h expected 0x%0h", act, req);
                end
            end
        end
    end

    initial begin
        logic [63:0] snap;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        sign_in   = 1'b0;
        exp_in    = '0;
        mant_in   = '0;
        pos_in    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_data", {sign_out, exp_out, mant_out, lead_onehot, zero_flag, uflow_flag, err_flag}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed vectors, streamed back-to-back
        send(1, 8'd100, 24'h000800, 5'd12, mk(1, 8'd88,  24'h800000, 24'h000800, 0, 0, 0));
        send(0, 8'd130, 24'hC00000, 5'd24, mk(0, 8'd130, 24'hC00000, 24'h800000, 0, 0, 0));
        send(1, 8'd50,  24'h000000, 5'd0,  mk(0, 8'd0,   24'h000000, 24'h000000, 1, 0, 0));
        send(1, 8'd12,  24'h000ABC, 5'd12, mk(0, 8'd0,   24'h000000, 24'h000800, 0, 1, 0));
        send(0, 8'd13,  24'h000800, 5'd12, mk(0, 8'd1,   24'h800000, 24'h000800, 0, 0, 0));
        send(1, 8'd0,   24'h123456, 5'd27, mk(0, 8'd0,   24'h000000, 24'h000000, 0, 0, 1));
        send(0, 8'd24,  24'h000001, 5'd1,  mk(0, 8'd1,   24'h800000, 24'h000001, 0, 0, 0));
        send(1, 8'd23,  24'h000001, 5'd1,  mk(0, 8'd0,   24'h000000, 24'h000001, 0, 1, 0));
        send(0, 8'd200, 24'h400000, 5'd25, mk(0, 8'd0,   24'h000000, 24'h000000, 0, 0, 1));
        send(1, 8'd9,   24'hFFFFFF, 5'd31, mk(0, 8'd0,   24'h000000, 24'h000000, 0, 0, 1));
        send(1, 8'd100, 24'h000F10, 5'd5,  mk(1, 8'd81,  24'h800000, 24'h000010, 0, 0, 0));
        drain();

        // Backpressure: 4 beats, 3-cycle stall once output becomes valid
        fork
            begin
                send(0, 8'd10,  24'h800001, 5'd24, mk(0, 8'd10,  24'h800001, 24'h800000, 0, 0, 0));
                send(0, 8'd10,  24'h080000, 5'd20, mk(0, 8'd6,   24'h800000, 24'h080000, 0, 0, 0));
                send(1, 8'd100, 24'h000003, 5'd2,  mk(1, 8'd78,  24'hC00000, 24'h000002, 0, 0, 0));
                send(1, 8'd255, 24'h00ABCD, 5'd16, mk(1, 8'd247, 24'hABCD00, 24'h008000, 0, 0, 0));
            end
            begin
                bit got = 0;
                for (int k = 0; k < 50 && !got; k++) begin
                    @(posedge clk);
                    #1;
                    if (out_valid) got = 1;
                end
                if (!got) begin
                    checks++;
                    failures++;
                    $display("FAIL stall_wait: out_valid never rose");
                end
                out_ready = 1'b0;
                @(negedge clk);
                snap = {5'd0, out_valid, sign_out, exp_out, mant_out, lead_onehot, zero_flag, uflow_flag, err_flag};
                for (int c = 0; c < 3; c++) begin
                    if (c != 0) @(negedge clk);
                    check("stall_in_ready", 64'(in_ready), 64'd0);
                    check("stall_frozen",
                          {5'd0, out_valid, sign_out, exp_out, mant_out, lead_onehot, zero_flag, uflow_flag, err_flag},
                          snap);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two beats in flight (one at the output, one in stage 1)
        out_ready = 1'b0;
        send(0, 8'd50, 24'h000100, 5'd9,  mk(0, 8'd35, 24'h800000, 24'h000100, 0, 0, 0));
        send(1, 8'd60, 24'h010000, 5'd17, mk(1, 8'd53, 24'h800000, 24'h010000, 0, 0, 0));
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        check("rst_mid_out_valid", 64'(out_valid), 64'd0);
        check("rst_mid_in_ready", 64'(in_ready), 64'd1);
        check("rst_mid_data", {sign_out, exp_out, mant_out, lead_onehot, zero_flag, uflow_flag, err_flag}, 64'd0);
        repeat (6) @(posedge clk);
        #1;
        check("rst_mid_no_stale", 64'(out_valid), 64'd0);

        // Pipeline still works after the flush
        send(0, 8'd30, 24'h000040, 5'd7, mk(0, 8'd13, 24'h800000, 24'h000040, 0, 0, 0));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
